// File: rtl/div_seq_32.sv
// ---------------------------------------------------------------------------
// div_seq_32
//   Multi-cycle signed divider for the CPU datapath. It takes one
//   non-restoring shift/add-subtract step per clock for WIDTH cycles, then
//   applies sign correction. The quotient and remainder are presented with
//   a one-cycle write strobe for the HI/LO registers.
//
// Ports
//   clock        rising-edge clock
//   clear        synchronous, active-high reset
//   start        divide request, only looked at while idle
//   dividend     signed dividend
//   divisor      signed divisor
//   busy         high from the cycle after an accepted start through FIX
//   done         one-cycle pulse, results valid on hi_out/lo_out
//   hilo_we      HI/LO write enable, identical to done
//   div_by_zero  high with done when the divisor was zero; held until the
//                next accepted start
//   hi_out       remainder, held until the next result
//   lo_out       quotient, held until the next result
// ---------------------------------------------------------------------------
module div_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   m;
    logic             sign_q;
    logic             sign_r;
    logic             dbz;

    // Operand magnitudes. The negation is taken modulo 2^WIDTH, so the most
    // negative value maps onto itself and is then treated as unsigned.
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

    // One non-restoring step. The partial remainder shifts in the next
    // dividend bit. M is added when the old A is negative and subtracted
    // otherwise. The new quotient bit is 1 exactly when the updated A is
    // non-negative.
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    assign a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
    assign a_step  = a[WIDTH] ? (a_shift + m) : (a_shift - m);
    assign q_step  = {q[WIDTH-2:0], ~a_step[WIDTH]};

    // Final correction. A negative partial remainder is restored once. The
    // quotient then takes the XOR of the operand signs, and the remainder
    // takes the sign of the dividend.
    logic [WIDTH:0]   a_fix;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    assign a_fix   = a[WIDTH] ? (a + m) : a;
    assign rem_mag = a_fix[WIDTH-1:0];
    assign quot    = sign_q ? -q : q;
    assign rem     = sign_r ? -rem_mag : rem_mag;

    // Sequencer and datapath registers. clear wins over everything. A divide
    // that is aborted mid-way never reaches DONE, so it never pulses done.
    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            count       <= '0;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz         <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            q     <= dividend;
                            dbz   <= 1'b1;
                            state <= FIX;
                        end else begin
                            q      <= dividend_mag;
                            m      <= {1'b0, divisor_mag};
                            a      <= '0;
                            count  <= '0;
                            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign_r <= dividend[WIDTH-1];
                            dbz    <= 1'b0;
                            state  <= ITER;
                        end
                    end
                end
                ITER: begin
                    a     <= a_step;
                    q     <= q_step;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz) begin
                        lo_out      <= '1;
                        hi_out      <= q;
                        div_by_zero <= 1'b1;
                    end else begin
                        a      <= a_fix;
                        lo_out <= quot;
                        hi_out <= rem;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The status outputs are decoded from the state. This keeps done and
    // busy mutually exclusive.
    assign busy    = (state == ITER) || (state == FIX);
    assign done    = (state == DONE);
    assign hilo_we = done;

endmodule
